// File: rtl/shifter_operand_pipe_if.sv
// Handshake and operand bus for the two-stage shifter operand pipeline.
interface shifter_operand_pipe_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IMM_W = 8,
    parameter int unsigned ROT_W = 4
);
    localparam int unsigned SA_W = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic             imm_en;
    logic [IMM_W-1:0] imm;
    logic [ROT_W-1:0] rot;
    logic [WIDTH-1:0] rm_val;
    logic [1:0]       sh_type;
    logic [SA_W-1:0]  sh_imm;
    logic             reg_sh;
    logic [7:0]       rs_val;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             c_out;

    modport master (
        output in_valid, imm_en, imm, rot, rm_val, sh_type, sh_imm, reg_sh, rs_val, c_in, out_ready,
        input  in_ready, out_valid, result, c_out
    );

    modport slave (
        input  in_valid, imm_en, imm, rot, rm_val, sh_type, sh_imm, reg_sh, rs_val, c_in, out_ready,
        output in_ready, out_valid, result, c_out
    );
endinterface

// File: rtl/shifter_operand_pipe.sv
// Two-stage barrel-shifter operand pipeline: S1 registers the request,
// S2 computes the shifted/rotated operand and its carry-out.
module shifter_operand_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IMM_W = 8,
    parameter int unsigned ROT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    shifter_operand_pipe_if.slave bus
);
    localparam int unsigned SA_W = $clog2(WIDTH);
    localparam logic [7:0]  W8   = 8'(WIDTH);

    typedef struct packed {
        logic             imm_en;
        logic [IMM_W-1:0] imm;
        logic [ROT_W-1:0] rot;
        logic [WIDTH-1:0] rm;
        logic [1:0]       sh_type;
        logic [SA_W-1:0]  sh_imm;
        logic             reg_sh;
        logic [7:0]       rs;
        logic             c_in;
    } op_t;

    op_t              op_in;
    op_t              s1_q;
    logic             s1_valid;
    logic             s2_valid;
    logic [WIDTH-1:0] result_q;
    logic             c_out_q;
    logic             stall;

    logic [WIDTH-1:0] res_c;
    logic             cy_c;
    logic [WIDTH-1:0] tmp;
    logic [7:0]       amt;
    logic [7:0]       na;
    logic [SA_W-1:0]  ra;

    assign op_in = '{imm_en:  bus.imm_en,
                     imm:     bus.imm,
                     rot:     bus.rot,
                     rm:      bus.rm_val,
                     sh_type: bus.sh_type,
                     sh_imm:  bus.sh_imm,
                     reg_sh:  bus.reg_sh,
                     rs:      bus.rs_val,
                     c_in:    bus.c_in};

    assign stall         = s2_valid && !bus.out_ready;
    assign bus.in_ready  = !stall;
    assign bus.out_valid = s2_valid;
    assign bus.result    = result_q;
    assign bus.c_out     = c_out_q;

    // Rotate right; a zero amount returns x unchanged since both halves equal x.
    function automatic logic [WIDTH-1:0] ror_f(input logic [WIDTH-1:0] x, input logic [SA_W-1:0] r);
        logic [SA_W-1:0] lr;
        lr = SA_W'(0) - r;
        return (x >> r) | (x << lr);
    endfunction

    // Stage 1: capture the request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (!stall) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_q <= op_in;
            end
        end
    end

    // Operand and carry computation from the S1 request
    always_comb begin
        res_c = s1_q.rm;
        cy_c  = s1_q.c_in;
        tmp   = '0;
        amt   = '0;
        na    = '0;
        ra    = '0;
        if (s1_q.imm_en) begin
            ra    = SA_W'({s1_q.rot, 1'b0});
            res_c = ror_f(WIDTH'(s1_q.imm), ra);
            cy_c  = (ra == '0) ? s1_q.c_in : res_c[WIDTH-1];
        end else begin
            amt = s1_q.reg_sh ? s1_q.rs : 8'(s1_q.sh_imm);
            // Immediate #0 encodes LSR/ASR #WIDTH and RRX; LSL #0 passes through
            if (!s1_q.reg_sh && amt == 8'd0) begin
                case (s1_q.sh_type)
                    2'b01, 2'b10: amt = W8;
                    2'b11: begin
                        res_c = {s1_q.c_in, s1_q.rm[WIDTH-1:1]};
                        cy_c  = s1_q.rm[0];
                    end
                    default: ;
                endcase
            end
            if (amt != 8'd0) begin
                case (s1_q.sh_type)
                    2'b00: begin
                        res_c = s1_q.rm << amt;
                        tmp   = s1_q.rm << (amt - 8'd1);
                        cy_c  = tmp[WIDTH-1];
                    end
                    2'b01: begin
                        res_c = s1_q.rm >> amt;
                        tmp   = s1_q.rm >> (amt - 8'd1);
                        cy_c  = tmp[0];
                    end
                    2'b10: begin
                        na    = (amt > W8) ? W8 : amt;
                        tmp   = $signed(s1_q.rm) >>> (na - 8'd1);
                        cy_c  = tmp[0];
                        res_c = $signed(tmp) >>> 1;
                    end
                    default: begin
                        ra    = amt[SA_W-1:0];
                        res_c = ror_f(s1_q.rm, ra);
                        cy_c  = res_c[WIDTH-1];
                    end
                endcase
            end
        end
    end

    // Stage 2: register the result; a bubble leaves result/c_out untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            result_q <= '0;
            c_out_q  <= 1'b0;
        end else if (flush) begin
            s2_valid <= 1'b0;
        end else if (!stall) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                result_q <= res_c;
                c_out_q  <= cy_c;
            end
        end
    end
endmodule

// File: tb/tb_shifter_operand_pipe.sv
// Bench for shifter_operand_pipe: directed corner cases plus a randomized
// stream scored against a behavioural model of the operand rules.
module tb_shifter_operand_pipe;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned IMM_W = 8;
    localparam int unsigned ROT_W = 4;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic flush = 1'b0;

    shifter_operand_pipe_if #(.WIDTH(WIDTH), .IMM_W(IMM_W), .ROT_W(ROT_W)) bus();

    shifter_operand_pipe #(.WIDTH(WIDTH), .IMM_W(IMM_W), .ROT_W(ROT_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        imm_en;
        bit [7:0]  imm;
        bit [3:0]  rot;
        bit [31:0] rm;
        bit [1:0]  ty;
        bit [4:0]  sh_imm;
        bit        reg_sh;
        bit [7:0]  rs;
        bit        c_in;
    } op_s;

    int checks  = 0;
    int errors  = 0;
    int n_deliv = 0;
    bit [32:0] q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural model: returns {c_out, result}
    function automatic bit [32:0] model(input op_s o);
        bit [31:0] r;
        bit [31:0] x;
        bit        c;
        int        n;
        int        a;
        r = '0;
        c = 1'b0;
        if (o.imm_en) begin
            x = 32'(o.imm);
            a = (2 * int'(o.rot)) % 32;
            for (int i = 0; i < 32; i++) r[i] = x[(i + a) % 32];
            c = (a == 0) ? o.c_in : r[31];
            return {c, r};
        end
        n = o.reg_sh ? int'(o.rs) : int'(o.sh_imm);
        if (n == 0) begin
            if (o.reg_sh || o.ty == 2'd0) return {o.c_in, o.rm};
            case (o.ty)
                2'd1:    return {o.rm[31], 32'd0};
                2'd2:    return {o.rm[31], {32{o.rm[31]}}};
                default: return {o.rm[0], o.c_in, o.rm[31:1]};
            endcase
        end
        case (o.ty)
            2'd0: begin
                if (n < 32)       begin r = o.rm << n; c = o.rm[32 - n]; end
                else if (n == 32) begin r = '0; c = o.rm[0]; end
                else              begin r = '0; c = 1'b0; end
            end
            2'd1: begin
                if (n < 32)       begin r = o.rm >> n; c = o.rm[n - 1]; end
                else if (n == 32) begin r = '0; c = o.rm[31]; end
                else              begin r = '0; c = 1'b0; end
            end
            2'd2: begin
                if (n >= 32) begin
                    r = {32{o.rm[31]}};
                    c = o.rm[31];
                end else begin
                    for (int i = 0; i < 32; i++) r[i] = (i + n < 32) ? o.rm[i + n] : o.rm[31];
                    c = o.rm[n - 1];
                end
            end
            default: begin
                a = n % 32;
                if (a == 0) begin
                    r = o.rm;
                    c = o.rm[31];
                end else begin
                    for (int i = 0; i < 32; i++) r[i] = o.rm[(i + a) % 32];
                    c = r[31];
                end
            end
        endcase
        return {c, r};
    endfunction

    function automatic op_s mk(input bit imm_en, input bit [7:0] imm, input bit [3:0] rot,
                               input bit [31:0] rm, input bit [1:0] ty, input bit [4:0] sh_imm,
                               input bit reg_sh, input bit [7:0] rs, input bit c_in);
        op_s o;
        o.imm_en = imm_en; o.imm = imm; o.rot = rot; o.rm = rm; o.ty = ty;
        o.sh_imm = sh_imm; o.reg_sh = reg_sh; o.rs = rs; o.c_in = c_in;
        return o;
    endfunction

    function automatic op_s rand_op();
        op_s o;
        o.imm_en = ($urandom_range(0, 3) == 0);
        o.imm    = 8'($urandom);
        o.rot    = 4'($urandom);
        o.rm     = $urandom;
        o.ty     = 2'($urandom);
        o.sh_imm = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        o.reg_sh = 1'($urandom);
        case ($urandom_range(0, 5))
            0:       o.rs = 8'd0;
            1:       o.rs = 8'd32;
            2:       o.rs = 8'd33;
            3:       o.rs = 8'd64;
            4:       o.rs = 8'($urandom_range(1, 31));
            default: o.rs = 8'($urandom);
        endcase
        o.c_in = 1'($urandom);
        return o;
    endfunction

    function automatic op_s bus_op();
        return mk(bus.imm_en, bus.imm, bus.rot, bus.rm_val, bus.sh_type, bus.sh_imm,
                  bus.reg_sh, bus.rs_val, bus.c_in);
    endfunction

    task automatic put(input op_s o);
        bus.in_valid = 1'b1;
        bus.imm_en   = o.imm_en;
        bus.imm      = o.imm;
        bus.rot      = o.rot;
        bus.rm_val   = o.rm;
        bus.sh_type  = o.ty;
        bus.sh_imm   = o.sh_imm;
        bus.reg_sh   = o.reg_sh;
        bus.rs_val   = o.rs;
        bus.c_in     = o.c_in;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single operand: silent after one edge, valid with the required value after two
    task automatic send_check(input string tag, input op_s o, input bit [31:0] er, input bit ec);
        put(o);
        step();
        idle();
        check({tag, "_lat1"}, bus.out_valid, 1'b0);
        step();
        check({tag, "_valid"}, bus.out_valid, 1'b1);
        check({tag, "_res"}, bus.result, er);
        check({tag, "_c"}, bus.c_out, ec);
        step();
    endtask

    // Scoreboard and handshake monitor, sampled mid-cycle
    bit        prev_stall = 1'b0;
    bit [31:0] prev_res;
    bit        prev_c;
    bit [32:0] exp_e;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            check("in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
            if (prev_stall && bus.out_valid) begin
                check("hold_result", bus.result, prev_res);
                check("hold_c_out", bus.c_out, prev_c);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_out", bus.out_valid, 1'b0);
                end else begin
                    exp_e = q.pop_front();
                    check("sb_result", bus.result, exp_e[31:0]);
                    check("sb_c_out", bus.c_out, exp_e[32]);
                    n_deliv++;
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_res   = bus.result;
            prev_c     = bus.c_out;
            if (flush) q.delete();
            else if (bus.in_valid && bus.in_ready) q.push_back(model(bus_op()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  base;
        int  sent;
        op_s ops[4];

        put(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        idle();
        bus.out_ready = 1'b1;

        // Reset state
        #12;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_result", bus.result, 32'd0);
        check("rst_c_out", bus.c_out, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed operand rules; first one offered right after reset release
        send_check("imm_ff_rot4", mk(1, 8'hFF, 4'd4, 32'h1234_5678, 2'd3, 5'd3, 1, 8'd5, 0), 32'hFF00_0000, 1'b1);
        send_check("imm_rot0", mk(1, 8'h5A, 4'd0, 32'hFFFF_FFFF, 2'd1, 5'd0, 0, 8'd0, 1), 32'h0000_005A, 1'b1);
        send_check("lsr0", mk(0, 0, 0, 32'h8000_0001, 2'd1, 5'd0, 0, 8'd0, 0), 32'h0, 1'b1);
        send_check("rrx", mk(0, 0, 0, 32'h0000_0003, 2'd3, 5'd0, 0, 8'd0, 1), 32'h8000_0001, 1'b1);
        send_check("asr0", mk(0, 0, 0, 32'h8000_0000, 2'd2, 5'd0, 0, 8'd0, 0), 32'hFFFF_FFFF, 1'b1);
        send_check("lsl_imm4", mk(0, 0, 0, 32'hF000_0001, 2'd0, 5'd4, 0, 8'd0, 0), 32'h0000_0010, 1'b1);
        send_check("lsl_rs32", mk(0, 0, 0, 32'hFFFF_FFFF, 2'd0, 5'd7, 1, 8'd32, 0), 32'h0, 1'b1);
        send_check("lsl_rs33", mk(0, 0, 0, 32'hFFFF_FFFF, 2'd0, 5'd7, 1, 8'd33, 1), 32'h0, 1'b0);
        send_check("lsl_rs0", mk(0, 0, 0, 32'hFFFF_FFFF, 2'd0, 5'd7, 1, 8'd0, 1), 32'hFFFF_FFFF, 1'b1);
        send_check("ror_rs64", mk(0, 0, 0, 32'h8000_0001, 2'd3, 5'd2, 1, 8'd64, 0), 32'h8000_0001, 1'b1);
        send_check("ror_rs1", mk(0, 0, 0, 32'h8000_0001, 2'd3, 5'd2, 1, 8'd1, 0), 32'hC000_0000, 1'b1);

        // Back-to-back stream with three cycles of back-pressure
        for (int i = 0; i < 4; i++) ops[i] = rand_op();
        base = n_deliv;
        sent = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            bus.out_ready = !(cyc >= 3 && cyc <= 5);
            if (sent < 4) put(ops[sent]);
            else idle();
            #1;
            if (cyc >= 3 && cyc <= 5 && bus.out_valid) check("stall_in_ready", bus.in_ready, 1'b0);
            if (bus.in_valid && bus.in_ready) sent++;
            step();
        end
        idle();
        check("stall_delivered", n_deliv - base, 4);

        // Flush with two operands in flight and a third offered
        base = n_deliv;
        bus.out_ready = 1'b0;
        put(rand_op());
        step();
        put(rand_op());
        step();
        put(rand_op());
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("flush_no_out", bus.out_valid, 1'b0);
            step();
        end
        check("flush_none_delivered", n_deliv - base, 0);
        send_check("post_flush", mk(0, 0, 0, 32'h0000_00F0, 2'd1, 5'd4, 0, 8'd0, 0), 32'h0000_000F, 1'b0);

        // Flush while ready: in-flight operand and the concurrent input both vanish
        base = n_deliv;
        put(rand_op());
        step();
        put(rand_op());
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        for (int k = 0; k < 3; k++) begin
            check("flush2_no_out", bus.out_valid, 1'b0);
            step();
        end
        check("flush2_none_delivered", n_deliv - base, 0);

        // Reset pulse mid-stream
        put(rand_op());
        step();
        put(rand_op());
        step();
        rst = 1'b1;
        #1;
        check("midrst_out_valid", bus.out_valid, 1'b0);
        check("midrst_in_ready", bus.in_ready, 1'b1);
        check("midrst_result", bus.result, 32'd0);
        idle();
        step();
        rst = 1'b0;
        base = n_deliv;
        for (int k = 0; k < 3; k++) begin
            check("postrst_no_out", bus.out_valid, 1'b0);
            step();
        end
        check("postrst_none_delivered", n_deliv - base, 0);

        // Randomized stream with back-pressure and occasional flush
        for (int cyc = 0; cyc < 400; cyc++) begin
            bus.out_ready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 3) != 0) put(rand_op());
            else idle();
            step();
        end
        flush = 1'b0;
        idle();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 20 && q.size() > 0; k++) step();
        check("drain_empty", q.size(), 0);
        step();
        check("final_idle", bus.out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
